sipo_deser: RTL

Parametrised serial-in/parallel-out deserializer with valid/ready handshaking on both sides, selectable bit order and a bit-counter-based framing state machine. Collects WIDTH serial bits into a word, hands the word to a single-entry output register, and applies backpressure to the serial side when that register is still occupied. It is the general-purpose successor to the plain shift-register SIPO and sits between bit-serial links and word-wide datapaths.

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_deser.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-in/parallel-out deserializer.
// Optional parity framing is selected with the SIPO_PARITY_EN macro.
package sipo_pkg;

    // Framing state: SHIFT collects data bits, PARITY collects the trailing parity bit.
    typedef enum logic [0:0] {
        SHIFT  = 1'b0,
        PARITY = 1'b1
    } sipo_state_e;

    // Width of the bit counter for a given word width (never narrower than one bit).
    function automatic int sipo_cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_deser.sv
// sipo_deser: collects WIDTH serial bits into a word and hands it to a
// single-entry output register with valid/ready handshaking on both sides.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame and the
// p_err sideband; without it a frame is exactly WIDTH bits.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and data stable until that edge, and ready never
// depends combinationally on the same interface's valid.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             s_valid,
    input  logic             s_in,
    output logic             s_ready,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
`ifdef SIPO_PARITY_EN
    output logic             p_err,
`endif
    output sipo_state_e      dbg_state
);

    localparam int CW = sipo_cnt_width(WIDTH);

    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    sipo_state_e      r_state;

    logic             w_slot_free;
    logic             w_last_data;
    logic             w_word_done;
    logic             w_accept;
    logic [WIDTH-1:0] w_next_word;

    assign w_slot_free = !p_valid || p_ready;
    assign w_last_data = (r_bit_cnt == CW'(WIDTH - 1));

`ifdef SIPO_PARITY_EN
    // The parity bit is the one that completes a frame.
    assign w_word_done = (r_state == PARITY);
`else
    // The last data bit completes a frame.
    assign w_word_done = (r_state == SHIFT) && w_last_data;
`endif

    // Stall only the bit that would load a word into an occupied slot; flush cycles accept nothing.
    assign s_ready  = !clear && !(w_word_done && !w_slot_free);
    assign w_accept = s_valid && s_ready;

    assign dbg_state = r_state;

    // Shift register contents after taking s_in, in the configured bit order.
    always_comb begin
        w_next_word = r_shift;
        if (MSB_FIRST) begin
            w_next_word = {r_shift[WIDTH-2:0], s_in};
        end else begin
            w_next_word = {s_in, r_shift[WIDTH-1:1]};
        end
    end

    // Framing FSM with bit counter, shift register and registered output slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_state   <= SHIFT;
            p_data    <= '0;
            p_valid   <= 1'b0;
`ifdef SIPO_PARITY_EN
            p_err     <= 1'b0;
`endif
        end else begin
            // Delivery empties the slot; a load below in the same cycle refills it.
            if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end

            if (clear) begin
                // Flush the partial frame only; the output slot is left untouched.
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_state   <= SHIFT;
            end else if (w_accept) begin
                case (r_state)
                    SHIFT: begin
                        r_shift <= w_next_word;
                        if (w_last_data) begin
                            r_bit_cnt <= '0;
`ifdef SIPO_PARITY_EN
                            r_state   <= PARITY;
`else
                            p_data    <= w_next_word;
                            p_valid   <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: begin
                        // Word is complete in r_shift; s_in is the even-parity bit.
                        p_data  <= r_shift;
                        p_err   <= (^r_shift) ^ s_in;
                        p_valid <= 1'b1;
                        r_state <= SHIFT;
                    end
`endif
                    default: begin
                        r_state <= SHIFT;
                    end
                endcase
            end
        end
    end

endmodule
